cache_line_write_merge: RTL and testbench

- Write-side datapath for the 8-way cache data array. Turns byte stores into byte-enabled line writes, and line fills into full-line writes.
- Byte stores: one 8-bit store at a 5-bit offset becomes a 256-bit line write with a one-hot 32-bit byte enable.
- Line fills: eight 32-bit memory beats are assembled into one 256-bit line, then committed with all byte enables set.
- Sits between the cache controller/memory interface and the data array. Targets the same way-index and 32B half-select the read path uses.

---
 rtl/cache_pkg.sv | 19 +
 rtl/byte_lane_decoder.sv | 15 +
 rtl/cache_line_write_merge.sv | 137 +++++++++++++
 tb/tb_cache_line_write_merge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache data-array write path.
// Imported by the line write merge datapath and its byte lane decoder.
package cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;
    localparam int WAY_W      = 3;
    localparam int BEAT_W     = 32;
    localparam int NUM_BEATS  = 8;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_e;

endpackage

// File: rtl/byte_lane_decoder.sv
// Maps a byte offset to a one-hot byte enable and places the byte
// into its lane of a zeroed half-line.
module byte_lane_decoder
    import cache_pkg::*;
(
    input  logic [OFFSET_W-1:0]   offset_i,
    input  logic [7:0]            data_i,
    output logic [LINE_BYTES-1:0] byte_en_o,
    output logic [LINE_W-1:0]     lane_o
);

    assign byte_en_o = LINE_BYTES'(1) << offset_i;
    assign lane_o    = LINE_W'(data_i) << {offset_i, 3'b000};

endmodule

// File: rtl/cache_line_write_merge.sv
// Write-side datapath for the cache data array: byte stores become
// byte-enabled line writes, eight fill beats become a full-line write.
module cache_line_write_merge
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_req,
    input  logic [2:0]   wr_way,
    input  logic         wr_half,
    input  logic [4:0]   wr_offset,
    input  logic [7:0]   wr_data,
    output logic         wr_ready,
    input  logic         fill_start,
    input  logic [2:0]   fill_way,
    input  logic         fill_half,
    input  logic         fill_beat_valid,
    input  logic [31:0]  fill_beat_data,
    output logic         arr_we,
    output logic [2:0]   arr_way,
    output logic         arr_half,
    output logic [255:0] arr_line,
    output logic [31:0]  arr_byte_en,
    output logic         busy
);

    state_e                state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0]     buf_q, buf_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic                  half_q, half_d;
    logic                  we_q, we_d;
    logic [WAY_W-1:0]      aw_q, aw_d;
    logic                  ah_q, ah_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [LINE_BYTES-1:0] be_q, be_d;
    logic                  busy_q, busy_d;

    logic [LINE_BYTES-1:0] dec_be;
    logic [LINE_W-1:0]     dec_line;

    byte_lane_decoder u_dec (
        .offset_i  (wr_offset),
        .data_i    (wr_data),
        .byte_en_o (dec_be),
        .lane_o    (dec_line)
    );

    assign wr_ready    = (state_q == IDLE) & ~fill_start;
    assign arr_we      = we_q;
    assign arr_way     = aw_q;
    assign arr_half    = ah_q;
    assign arr_line    = line_q;
    assign arr_byte_en = be_q;
    assign busy        = busy_q;

    // Next-state, beat assembly and registered array-side outputs
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        way_d   = way_q;
        half_d  = half_q;
        we_d    = 1'b0;
        aw_d    = aw_q;
        ah_d    = ah_q;
        line_d  = line_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    way_d   = fill_way;
                    half_d  = fill_half;
                    beat_d  = '0;
                    state_d = FILL;
                end else if (wr_req) begin
                    we_d   = 1'b1;
                    aw_d   = wr_way;
                    ah_d   = wr_half;
                    be_d   = dec_be;
                    line_d = dec_line;
                end
            end
            FILL: begin
                if (fill_beat_valid) begin
                    buf_d[beat_q*BEAT_W +: BEAT_W] = fill_beat_data;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == BEAT_CNT_W'(NUM_BEATS - 1)) begin
                        state_d = COMMIT;
                        we_d    = 1'b1;
                        aw_d    = way_q;
                        ah_d    = half_q;
                        be_d    = '1;
                        line_d  = buf_d;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any fill in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
            way_q   <= '0;
            half_q  <= 1'b0;
            we_q    <= 1'b0;
            aw_q    <= '0;
            ah_q    <= 1'b0;
            line_q  <= '0;
            be_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            way_q   <= way_d;
            half_q  <= half_d;
            we_q    <= we_d;
            aw_q    <= aw_d;
            ah_q    <= ah_d;
            line_q  <= line_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_cache_line_write_merge.sv
// Self-checking bench for cache_line_write_merge: store table, directed
// fill/priority/reset sequences and random traffic against a queue model.
module tb_cache_line_write_merge;

    logic         clk;
    logic         reset;
    logic         wr_req;
    logic [2:0]   wr_way;
    logic         wr_half;
    logic [4:0]   wr_offset;
    logic [7:0]   wr_data;
    logic         wr_ready;
    logic         fill_start;
    logic [2:0]   fill_way;
    logic         fill_half;
    logic         fill_beat_valid;
    logic [31:0]  fill_beat_data;
    logic         arr_we;
    logic [2:0]   arr_way;
    logic         arr_half;
    logic [255:0] arr_line;
    logic [31:0]  arr_byte_en;
    logic         busy;

    cache_line_write_merge dut (
        .clk             (clk),
        .reset           (reset),
        .wr_req          (wr_req),
        .wr_way          (wr_way),
        .wr_half         (wr_half),
        .wr_offset       (wr_offset),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .fill_start      (fill_start),
        .fill_way        (fill_way),
        .fill_half       (fill_half),
        .fill_beat_valid (fill_beat_valid),
        .fill_beat_data  (fill_beat_data),
        .arr_we          (arr_we),
        .arr_way         (arr_way),
        .arr_half        (arr_half),
        .arr_line        (arr_line),
        .arr_byte_en     (arr_byte_en),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fs;
        logic [2:0]  fw;
        logic        fh;
        logic        bv;
        logic [31:0] bd;
        logic        wr;
        logic [2:0]  ww;
        logic        wh;
        logic [4:0]  wo;
        logic [7:0]  wd;
    } in_t;

    typedef struct {
        logic [2:0]   way;
        logic         half;
        logic [4:0]   off;
        logic [7:0]   data;
        logic [31:0]  exp_be;
        logic [255:0] exp_line;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 collecting beats, 2 writing line
    int           m_mode;
    logic [31:0]  m_beats[$];
    logic [2:0]   m_way;
    logic         m_half;
    logic         e_we;
    logic [2:0]   e_way;
    logic         e_half;
    logic [255:0] e_line;
    logic [31:0]  e_be;
    logic         e_busy;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_beats.delete();
        m_way  = '0;
        m_half = 1'b0;
        e_we   = 1'b0;
        e_way  = '0;
        e_half = 1'b0;
        e_line = '0;
        e_be   = '0;
        e_busy = 1'b0;
    endtask

    task automatic check_outs();
        chk("arr_we", arr_we, e_we);
        chk("arr_way", arr_way, e_way);
        chk("arr_half", arr_half, e_half);
        chk("arr_byte_en", arr_byte_en, e_be);
        chk("arr_line", arr_line, e_line);
        chk("busy", busy, e_busy);
    endtask

    function automatic in_t idle_in();
        in_t s = '0;
        return s;
    endfunction

    function automatic in_t st(input logic [2:0] w, input logic h,
                               input logic [4:0] o, input logic [7:0] d);
        in_t s = '0;
        s.wr = 1'b1;
        s.ww = w;
        s.wh = h;
        s.wo = o;
        s.wd = d;
        return s;
    endfunction

    function automatic in_t fst(input logic [2:0] w, input logic h);
        in_t s = '0;
        s.fs = 1'b1;
        s.fw = w;
        s.fh = h;
        return s;
    endfunction

    function automatic in_t bt(input logic [31:0] d);
        in_t s = '0;
        s.bv = 1'b1;
        s.bd = d;
        return s;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input in_t s);
        fill_start      = s.fs;
        fill_way        = s.fw;
        fill_half       = s.fh;
        fill_beat_valid = s.bv;
        fill_beat_data  = s.bd;
        wr_req          = s.wr;
        wr_way          = s.ww;
        wr_half         = s.wh;
        wr_offset       = s.wo;
        wr_data         = s.wd;
        #1;
        chk("wr_ready", wr_ready, (m_mode == 0) && !s.fs);
        e_we = 1'b0;
        case (m_mode)
            0: begin
                if (s.fs) begin
                    m_mode = 1;
                    m_beats.delete();
                    m_way  = s.fw;
                    m_half = s.fh;
                    e_busy = 1'b1;
                end else begin
                    e_busy = 1'b0;
                    if (s.wr) begin
                        e_we   = 1'b1;
                        e_way  = s.ww;
                        e_half = s.wh;
                        e_be   = 32'd1 << s.wo;
                        e_line = 256'(s.wd) << (8 * s.wo);
                    end
                end
            end
            1: begin
                e_busy = 1'b1;
                if (s.bv) m_beats.push_back(s.bd);
                if (m_beats.size() == 8) begin
                    for (int k = 0; k < 8; k++)
                        e_line[32*k +: 32] = m_beats[k];
                    e_we   = 1'b1;
                    e_be   = 32'hFFFF_FFFF;
                    e_way  = m_way;
                    e_half = m_half;
                    m_mode = 2;
                end
            end
            default: begin
                m_mode = 0;
                e_busy = 1'b0;
            end
        endcase
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{3'd5, 1'b1, 5'd31, 8'hA5, 32'h8000_0000, 256'hA5 << 248};
        tbl[1] = '{3'd0, 1'b0, 5'd0,  8'h11, 32'h0000_0001, 256'h11};
        tbl[2] = '{3'd0, 1'b0, 5'd1,  8'h22, 32'h0000_0002, 256'h22 << 8};
        tbl[3] = '{3'd7, 1'b0, 5'd16, 8'h3C, 32'h0001_0000, 256'h3C << 128};
        tbl[4] = '{3'd3, 1'b1, 5'd8,  8'hFF, 32'h0000_0100, 256'hFF << 64};
        tbl[5] = '{3'd1, 1'b0, 5'd30, 8'h00, 32'h4000_0000, 256'h0};

        reset = 1'b1;
        fill_start = 0; fill_way = 0; fill_half = 0;
        fill_beat_valid = 0; fill_beat_data = 0;
        wr_req = 0; wr_way = 0; wr_half = 0; wr_offset = 0; wr_data = 0;
        model_reset();
        #3;
        check_outs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // store table, applied back-to-back
        for (int i = 0; i < 6; i++) begin
            cycle(st(tbl[i].way, tbl[i].half, tbl[i].off, tbl[i].data));
            chk("tbl_we", arr_we, 1'b1);
            chk("tbl_be", arr_byte_en, tbl[i].exp_be);
            chk("tbl_line", arr_line, tbl[i].exp_line);
            chk("tbl_way", arr_way, tbl[i].way);
        end
        cycle(idle_in());
        chk("store_pulse_end", arr_we, 1'b0);

        // fill with gaps
        cycle(fst(3'd2, 1'b0));
        for (int k = 0; k < 8; k++) begin
            cycle(bt(32'h1111_1111 * k));
            if (k < 7) cycle(idle_in());
        end
        chk("fill_we", arr_we, 1'b1);
        chk("fill_be", arr_byte_en, 32'hFFFF_FFFF);
        chk("fill_beat5", arr_line[191:160], 32'h5555_5555);
        cycle(idle_in());

        // fill_start beats a simultaneous store; store held through fill
        begin
            in_t s;
            s = fst(3'd6, 1'b1);
            s.wr = 1'b1; s.ww = 3'd4; s.wo = 5'd9; s.wd = 8'h5A;
            cycle(s);
            for (int k = 0; k < 8; k++) begin
                s = bt(32'hC0DE_0000 + k);
                s.wr = 1'b1; s.ww = 3'd4; s.wo = 5'd9; s.wd = 8'h5A;
                cycle(s);
            end
            s = st(3'd4, 1'b0, 5'd9, 8'h5A);
            cycle(s);
            cycle(s);
            chk("held_store_be", arr_byte_en, 32'h0000_0200);
        end
        cycle(idle_in());

        // stray beats in idle and in the commit cycle
        cycle(bt(32'hDEAD_BEEF));
        cycle(fst(3'd1, 1'b1));
        for (int k = 0; k < 8; k++) cycle(bt(32'hA000_0000 + k));
        cycle(bt(32'hBAD0_BAD0));
        cycle(fst(3'd3, 1'b0));
        for (int k = 0; k < 8; k++) cycle(bt(32'h0B00_0000 + k));
        chk("stray_beat0", arr_line[31:0], 32'h0B00_0000);
        cycle(idle_in());

        // asynchronous reset after three beats of a fill
        cycle(fst(3'd7, 1'b1));
        for (int k = 0; k < 3; k++) cycle(bt(32'hEEEE_0000 + k));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        chk("rst_ready", wr_ready, 1'b1);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cycle(fst(3'd5, 1'b0));
        for (int k = 0; k < 8; k++) cycle(bt(32'h7000_0000 + k));
        chk("post_rst_line", arr_line[255:224], 32'h7000_0007);
        cycle(idle_in());

        // random traffic
        for (int n = 0; n < 400; n++) begin
            in_t s;
            s.fs = ($urandom_range(0, 11) == 0);
            s.fw = 3'($urandom);
            s.fh = 1'($urandom);
            s.bv = ($urandom_range(0, 2) != 0);
            s.bd = $urandom;
            s.wr = 1'($urandom);
            s.ww = 3'($urandom);
            s.wh = 1'($urandom);
            s.wo = 5'($urandom);
            s.wd = 8'($urandom);
            cycle(s);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
